// File: rtl/payload_feeder_pkg.sv
// rtl/payload_feeder_pkg.sv - FSM states, class table and class_match shared by the payload feeder.
package payload_feeder_pkg;

  localparam int NUM_CLASSES_DEF = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOD,
    ST_STREAM,
    ST_DRAIN,
    ST_REPORT
  } feeder_state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_EQ,
    CLS_RANGE,
    CLS_PAIR
  } cls_kind_t;

  typedef struct packed {
    cls_kind_t  kind;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       negate;
  } cls_entry_t;

  function automatic cls_entry_t mk_entry(input cls_kind_t kind, input logic [7:0] lo,
                                          input logic [7:0] hi, input logic negate);
    cls_entry_t e;
    e.kind   = kind;
    e.lo     = lo;
    e.hi     = hi;
    e.negate = negate;
    return e;
  endfunction

  // 0..95 printable singles, 96..107 engine-oriented classes, 108..127 control singles.
  function automatic cls_entry_t class_entry(input int unsigned idx);
    cls_entry_t e;
    if (idx < 96) begin
      e = mk_entry(CLS_EQ, 8'(idx + 32), 8'h00, 1'b0);
    end else if (idx >= 108 && idx < 128) begin
      e = mk_entry(CLS_EQ, 8'(idx - 108), 8'h00, 1'b0);
    end else begin
      case (idx)
        96:      e = mk_entry(CLS_RANGE, 8'h30, 8'h39, 1'b0);
        97:      e = mk_entry(CLS_RANGE, 8'h61, 8'h7A, 1'b0);
        98:      e = mk_entry(CLS_RANGE, 8'h41, 8'h5A, 1'b0);
        99:      e = mk_entry(CLS_PAIR,  8'h09, 8'h20, 1'b0);
        100:     e = mk_entry(CLS_PAIR,  8'h0A, 8'h0D, 1'b1);
        101:     e = mk_entry(CLS_EQ,    8'h3C, 8'h00, 1'b0);
        102:     e = mk_entry(CLS_EQ,    8'h2F, 8'h00, 1'b0);
        103:     e = mk_entry(CLS_EQ,    8'h3E, 8'h00, 1'b0);
        104:     e = mk_entry(CLS_EQ,    8'h63, 8'h00, 1'b0);
        105:     e = mk_entry(CLS_EQ,    8'h68, 8'h00, 1'b0);
        106:     e = mk_entry(CLS_EQ,    8'h61, 8'h00, 1'b0);
        107:     e = mk_entry(CLS_EQ,    8'h74, 8'h00, 1'b0);
        default: e = mk_entry(CLS_NONE,  8'h00, 8'h00, 1'b0);
      endcase
    end
    return e;
  endfunction

  function automatic logic class_match(input int unsigned idx, input logic [7:0] b);
    cls_entry_t e;
    logic       hit;
    e = class_entry(idx);
    case (e.kind)
      CLS_EQ:    hit = (b == e.lo);
      CLS_RANGE: hit = (b >= e.lo) && (b <= e.hi);
      CLS_PAIR:  hit = (b == e.lo) || (b == e.hi);
      default:   hit = 1'b0;
    endcase
    return hit ^ e.negate;
  endfunction

endpackage

// File: rtl/payload_char_decoder.sv
// rtl/payload_char_decoder.sv - byte to registered class lines plus en.
// PAYLOAD_FEEDER_NOCASE_EN folds A-Z onto a-z before decode.
module payload_char_decoder
  import payload_feeder_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   accept,
  input  logic [7:0]             data,
  output logic                   en,
  output logic [NUM_CLASSES-1:0] char_cls
);

  logic [7:0]             folded;
  logic [NUM_CLASSES-1:0] cls_next;

`ifdef PAYLOAD_FEEDER_NOCASE_EN
  always_comb begin
    folded = data;
    if (data >= 8'h41 && data <= 8'h5A) folded = data | 8'h20;
  end
`else
  assign folded = data;
`endif

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cls
    assign cls_next[i] = class_match(i, folded);
  end

  // char_cls only moves on an accepted byte so engines see stable lines across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      char_cls <= '0;
    end else begin
      en <= accept;
      if (accept) char_cls <= cls_next;
    end
  end

endmodule

// File: rtl/payload_char_feeder.sv
// rtl/payload_char_feeder.sv - frames payload packets for the engine array and returns one match vector per packet.
// PAYLOAD_FEEDER_NOCASE_EN (in payload_char_decoder) enables case-insensitive class decode.
module payload_char_feeder
  import payload_feeder_pkg::*;
#(
  parameter int NUM_CLASSES  = NUM_CLASSES_DEF,
  parameter int NUM_ENGINES  = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   sod,
  output logic                   en,
  output logic [NUM_CLASSES-1:0] char_cls,
  input  logic [NUM_ENGINES-1:0] eng_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NUM_ENGINES-1:0] res_match,
  output logic [15:0]            res_len
);

  // DRAIN starts on the cycle the last en is high, so the count runs down to zero inclusive.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  feeder_state_t state, state_next;
  logic [3:0]    drain_cnt;
  logic          accept;
  logic          drain_done;

  assign accept     = s_tvalid && s_tready;
  assign drain_done = (state == ST_DRAIN) && (drain_cnt == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_tready   = 1'b0;
    sod        = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_tvalid) state_next = ST_SOD;
      end
      ST_SOD: begin
        sod        = 1'b1;
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == 4'd0) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drain_cnt <= 4'd0;
      res_len   <= 16'd0;
      res_match <= '0;
    end else begin
      if (state == ST_SOD) begin
        res_len <= 16'd0;
      end else if (accept && res_len != 16'hFFFF) begin
        res_len <= res_len + 16'd1;
      end

      if (accept && s_tlast) begin
        drain_cnt <= DRAIN_LOAD;
      end else if (state == ST_DRAIN && drain_cnt != 4'd0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end

      if (drain_done) res_match <= eng_out;
    end
  end

  payload_char_decoder #(
    .NUM_CLASSES (NUM_CLASSES)
  ) u_decoder (
    .clk      (clk),
    .rst_n    (resetn),
    .accept   (accept),
    .data     (s_tdata),
    .en       (en),
    .char_cls (char_cls)
  );

endmodule

// File: tb/tb_payload_char_feeder.sv
// tb/tb_payload_char_feeder.sv - randomized self-checking bench for payload_char_feeder with a behavioural engine.
`timescale 1ns/1ps
module tb_payload_char_feeder;

  localparam int NC    = 128;
  localparam int NE    = 64;
  localparam int DRAIN = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] cl;
    logic       opened;
    logic       matched;
  } mst_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          sod;
  logic          en;
  logic [NC-1:0] char_cls;
  logic [NE-1:0] eng_out;
  logic          res_valid;
  logic          res_ready;
  logic [NE-1:0] res_match;
  logic [15:0]   res_len;

  always #5 clk = ~clk;

  payload_char_feeder #(
    .NUM_CLASSES  (NC),
    .NUM_ENGINES  (NE),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .sod       (sod),
    .en        (en),
    .char_cls  (char_cls),
    .eng_out   (eng_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_match (res_match),
    .res_len   (res_len)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef PAYLOAD_FEEDER_NOCASE_EN
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
`endif
    return b;
  endfunction

  function automatic logic [7:0] pat_ch(input bit close, input int pos);
    string s;
    s = close ? "</chat>" : "<chat>";
    return s[pos];
  endfunction

  // Streaming search for the open tag, then any non CR/LF bytes, then the close tag; sticky once found.
  function automatic mst_t step(input mst_t s, input logic [7:0] c);
    mst_t n;
    n = s;
    if (s.matched) return s;
    if (s.opened) begin
      if (c == 8'h0A || c == 8'h0D) begin
        n.opened = 1'b0;
        n.cl     = 3'd0;
      end else if (c == pat_ch(1'b1, int'(s.cl))) begin
        n.cl = s.cl + 3'd1;
        if (n.cl == 3'd7) n.matched = 1'b1;
      end else begin
        n.cl = (c == 8'h3C) ? 3'd1 : 3'd0;
      end
    end
    if (c == pat_ch(1'b0, int'(s.op))) n.op = s.op + 3'd1;
    else n.op = (c == 8'h3C) ? 3'd1 : 3'd0;
    if (n.op == 3'd6) begin
      n.op = 3'd0;
      if (!n.opened) begin
        n.opened = 1'b1;
        n.cl     = 3'd0;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] sym_of(input logic [NC-1:0] c);
    if (c[101]) return 8'h3C;
    if (c[102]) return 8'h2F;
    if (c[103]) return 8'h3E;
    if (c[104]) return 8'h63;
    if (c[105]) return 8'h68;
    if (c[106]) return 8'h61;
    if (c[107]) return 8'h74;
    if (!c[100]) return 8'h0A;
    return 8'h78;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Engine 0 stand-in: sees only sod/en/char_cls, state visible 2 cycles after en.
  mst_t         eng_st;
  logic         eng_o0;
  logic [NE-1:1] eng_hi;
  assign eng_out = {eng_hi, eng_o0};

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      eng_st <= '0;
      eng_o0 <= 1'b0;
    end else begin
      if (sod)     eng_st <= '0;
      else if (en) eng_st <= step(eng_st, sym_of(char_cls));
      eng_o0 <= eng_st.matched;
    end
  end

  int            cyc = 0;
  logic [7:0]    pend[$];
  int            en_cnt = 0, sod_cnt = 0, hs_cnt = 0, last_en_cyc = 0;
  bit            have_prev = 0, rv_prev = 0, any_rv = 0;
  logic [NC-1:0] prev_cls;
  logic [NE-1:0] held_match;
  logic [15:0]   held_len;
  logic [NE-1:0] exp_match_q[$];
  logic [15:0]   exp_len_q[$];
  int            exp_n_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    logic [7:0] b;
    if (sod) sod_cnt++;
    if (en) begin
      if (en_cnt == 0) chk("sod_before_en", sod_cnt, 1);
      en_cnt++;
      last_en_cyc = cyc;
      chk("en_has_byte", pend.size() != 0, 1);
      if (pend.size() != 0) begin
        b = fold(pend.pop_front());
        chk("cls_sig", {char_cls[107], char_cls[101], char_cls[100], char_cls[97], char_cls[96]},
            {b == 8'h74, b == 8'h3C, b != 8'h0A && b != 8'h0D,
             b >= 8'h61 && b <= 8'h7A, b >= 8'h30 && b <= 8'h39});
        if (b >= 8'h20 && b <= 8'h7F) chk("cls_eq", char_cls[b - 8'h20], 1);
      end
    end else if (have_prev) begin
      chk("cls_hold", char_cls == prev_cls, 1);
    end
    prev_cls  = char_cls;
    have_prev = 1;
    if (s_tvalid && s_tready) pend.push_back(s_tdata);
    if (res_valid) begin
      any_rv = 1;
      if (!rv_prev) begin
        chk("res_latency", cyc - last_en_cyc, DRAIN);
      end else begin
        chk("res_match_stable", res_match, held_match);
        chk("res_len_stable", res_len, held_len);
      end
      chk("tready_in_report", s_tready, 0);
      held_match = res_match;
      held_len   = res_len;
      if (res_ready) begin
        chk("result_expected", exp_len_q.size() != 0, 1);
        if (exp_len_q.size() != 0) begin
          chk("res_match", res_match, exp_match_q.pop_front());
          chk("res_len", res_len, exp_len_q.pop_front());
          chk("en_count", en_cnt, exp_n_q.pop_front());
          chk("sod_count", sod_cnt, 1);
        end
        en_cnt  = 0;
        sod_cnt = 0;
        hs_cnt++;
      end
    end
    rv_prev = res_valid && !res_ready;
  end

  task automatic check_reset(input string p);
    chk({p, "_tready"}, s_tready, 0);
    chk({p, "_sod"}, sod, 0);
    chk({p, "_en"}, en, 0);
    chk({p, "_cls"}, |char_cls, 0);
    chk({p, "_res_valid"}, res_valid, 0);
    chk({p, "_res_match"}, res_match, 0);
    chk({p, "_res_len"}, res_len, 0);
  endtask

  task automatic send_pkt(input bq_t d, input int gap_mode, input bit mark_last);
    int i = 0;
    int guard = 0;
    bit acc;
    bit ph = 1'b0;
    while (i < d.size() && guard < d.size() * 4 + 100) begin
      case (gap_mode)
        0:       s_tvalid = 1'b1;
        1:       s_tvalid = ph;
        default: s_tvalid = ($urandom_range(0, 3) != 0);
      endcase
      ph      = !ph;
      s_tdata = d[i];
      s_tlast = mark_last && (i == d.size() - 1);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (i < d.size()) chk("send_timeout", i, d.size());
  endtask

  task automatic run_pkt(input bq_t d, input int gap_mode, input int stall);
    mst_t        s;
    logic [63:0] r;
    int          target;
    int          g;
    s = '0;
    foreach (d[k]) s = step(s, fold(d[k]));
    r      = {$urandom, $urandom};
    eng_hi = r[NE-1:1];
    exp_match_q.push_back({eng_hi, s.matched});
    exp_len_q.push_back(d.size() > 65535 ? 16'hFFFF : 16'(d.size()));
    exp_n_q.push_back(d.size());
    target    = hs_cnt + 1;
    res_ready = (stall == 0);
    send_pkt(d, gap_mode, 1'b1);
    if (stall > 0) begin
      g = 0;
      while (!res_valid && g < 100) begin
        @(posedge clk);
        #1;
        g++;
      end
      chk("res_valid_wait", res_valid, 1);
      repeat (stall) @(posedge clk);
      #1;
      res_ready = 1'b1;
    end
    g = 0;
    while (hs_cnt < target && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("handshake", hs_cnt, target);
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bq_t q;
    bq_t tok;
    s_tvalid  = 1'b0;
    s_tdata   = 8'h00;
    s_tlast   = 1'b0;
    res_ready = 1'b1;
    eng_hi    = '0;
    resetn    = 1'b1;
    #2;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_pkt(str2q("<chat>x</chat>"), 0, 0);
    q = str2q("<chat>x");
    q.push_back(8'h0A);
    tok = str2q("</chat>");
    foreach (tok[k]) q.push_back(tok[k]);
    run_pkt(q, 0, 0);
    q.delete();
    q.push_back(8'h3C);
    run_pkt(q, 0, 0);
    run_pkt(str2q("<chat>x</chat>"), 1, 0);
    run_pkt(str2q("ab<chat>yz</chat>"), 0, 20);
    run_pkt(str2q("<CHAT>x</CHAT>"), 0, 0);

    for (int p = 0; p < 20; p++) begin
      q.delete();
      for (int t = 0; t < $urandom_range(1, 8); t++) begin
        case ($urandom_range(0, 7))
          0: tok = str2q("<chat>");
          1: tok = str2q("</chat>");
          2: tok = str2q("x");
          3: begin
            tok.delete();
            tok.push_back(8'h0A);
          end
          4: begin
            tok.delete();
            tok.push_back(8'h0D);
          end
          5: tok = str2q("<");
          6: tok = str2q("ChAt");
          default: begin
            tok.delete();
            tok.push_back(8'($urandom_range(0, 255)));
          end
        endcase
        foreach (tok[k]) q.push_back(tok[k]);
      end
      run_pkt(q, 2, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
    end

    send_pkt(str2q("<chat>abc"), 0, 1'b0);
    resetn    = 1'b0;
    have_prev = 0;
    #1;
    check_reset("mid_rst");
    pend.delete();
    en_cnt  = 0;
    sod_cnt = 0;
    rv_prev = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    any_rv = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_res_after_rst", any_rv, 0);
    run_pkt(str2q("<chat>ok</chat>"), 0, 0);

    q = str2q("<chat>");
    repeat (70000 - 13) q.push_back(8'h78);
    tok = str2q("</chat>");
    foreach (tok[k]) q.push_back(tok[k]);
    run_pkt(q, 0, 0);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/payload_char_feeder.md
# payload_char_feeder

Front end of the payload-engine array: accepts payload bytes on a ready/valid stream and frames each packet for the engines. It drives the per-packet `sod` clear pulse, the byte-qualifying `en`, and the registered character-class lines (`in_0 … in_N`) that every `engine_*` consumes. After the packet ends it waits for the engine pipelines to drain, samples every engine's `out`, and returns one match vector per packet on a ready/valid result port.

## Interface
Parameters:
- `NUM_CLASSES`, 128: width of the class bus; the class index equals the engine `in_<idx>` number.
- `NUM_ENGINES`, 64: number of engine `out` lines sampled.
- `DRAIN_CYCLES`, 3: cycles after the last byte's `en` before `eng_out` is sampled; legal range 2–15.

Ports:
- `clk` input 1: single clock; all logic rising-edge.
- `resetn` input 1: asynchronous, active-low reset.
- `s_tdata` input 8: payload byte.
- `s_tvalid` input 1: byte valid.
- `s_tlast` input 1: last byte of packet.
- `s_tready` output 1: byte accepted when `s_tvalid && s_tready`.
- `sod` output 1: one-cycle engine clear pulse at start of each packet.
- `en` output 1: engine clock enable; high exactly one cycle per accepted byte.
- `char_cls` output NUM_CLASSES: registered class lines for the current byte.
- `eng_out` input NUM_ENGINES: engine match outputs.
- `res_valid` output 1: result available.
- `res_ready` input 1: result consumed when `res_valid && res_ready`.
- `res_match` output NUM_ENGINES: sampled `eng_out`.
- `res_len` output 16: packet byte count, saturating.

## Operation
- States: IDLE, SOD, STREAM, DRAIN, REPORT.
- IDLE: `s_tready`=0. Moves to SOD when `s_tvalid`=1; no byte is consumed.
- SOD: `sod`=1 for exactly this cycle and `s_tready`=0. The length counter clears. Next state is STREAM.
- STREAM: `s_tready`=1. Each accepted byte is decoded and registered into `char_cls`, with `en`=1 on the following cycle. A cycle with no accepted byte gives `en`=0, and `char_cls` holds its value. On an accepted byte with `s_tlast`=1, go to DRAIN.
- DRAIN: `s_tready`=0. The drain counter loads `DRAIN_CYCLES`, counted from the cycle in which the last byte's `en`=1. On expiry, capture `res_match`<=`eng_out` and go to REPORT.
- REPORT: `res_valid`=1 and the outputs stay stable until the handshake. On handshake, go to IDLE; the `sod` of the next packet follows through SOD.
- Class decode: `char_cls[i]` = class_match(i, byte) from the shared table. Each class is an equality, a range, or a negated set (e.g. `[^\r\n]`).
- `res_len`: increments per accepted byte and saturates at 16'hFFFF with no wrap.
- Minimum packet: one byte, since `s_tlast` falls on the first beat.
- `s_tvalid` dropping mid-packet is legal; the gaps give `en`=0 and engines hold state.
- `resetn` asserted in any state: the FSM returns to IDLE and the whole packet is discarded, with no result.
- Reset values: `s_tready`=0, `sod`=0, `en`=0, `char_cls`=0, `res_valid`=0, `res_match`=0, `res_len`=0.

## Timing
- Byte accepted at cycle t gives `en`/`char_cls` at t+1.
- Engine state registers update at the end of t+1; the end state is visible from t+3. This is why `DRAIN_CYCLES`=3 is the default.
- `sod` leads the first `en` of its packet by at least 1 cycle.
- Back-to-back packets have a minimum of 1 (IDLE) + 1 (SOD) + DRAIN_CYCLES + 1 (REPORT) dead cycles, plus the time for `res_ready`.
- `res_ready` held high gives a REPORT dwell of exactly 1 cycle.
- `res_ready` low stalls the input indefinitely; no result is dropped.

## Configuration
- `PAYLOAD_FEEDER_NOCASE_EN` defined: bytes 0x41–0x5A are folded to 0x61–0x7A before class decode. This gives case-insensitive (`/i`) matching for every engine.
- Undefined: bytes are decoded as received. Case-insensitive rules then need their own dual-case classes in the table.

## Structure
- Package `payload_feeder_pkg` holds:
  - the FSM state enum;
  - the `NUM_CLASSES` default;
  - the class table (kind, lo, hi, negate per index);
  - the `class_match` function.
- Sub-module `payload_char_decoder`: byte in, NUM_CLASSES registered lines out, with `en` generation. It carries the case-fold logic under the macro.

## Test plan
- Packet "<chat>x</chat>" (14 bytes), `res_ready`=1, with the engine_0_67 instance wired to `char_cls`/`eng_out[0]`:
  - `sod` pulses once; `en` is high for 14 cycles;
  - `res_match[0]`=1 and `res_len`=14;
  - `res_valid` asserts 3 cycles after the last `en`.
- Same packet with 0x0A inserted inside the text gives `res_match[0]`=0 and `res_len`=15.
- Single byte 0x3C with `s_tlast`=1:
  - `en` is high for exactly 1 cycle;
  - `char_cls[101]`=1;
  - the result arrives with `res_len`=1 and `res_match`=0.
- `s_tvalid` toggling every other cycle mid-packet gives `en` gaps and an unchanged match result. `res_ready`=0 for 20 cycles holds `s_tready`=0 and keeps `res_*` stable.
- 70000-byte packet gives `res_len`=16'hFFFF.
- `resetn` pulsed in STREAM: all outputs go to reset values and no `res_valid` appears. The next packet produces a fresh `sod` and a correct result.
- With `PAYLOAD_FEEDER_NOCASE_EN`: "<CHAT>x</CHAT>" gives `res_match[0]`=1. Without it, the same input gives 0.
